// File: rtl/crop_downsample_grid.sv
// Crop-and-downsample stage: samples an N_COLS x N_ROWS grid from a raster pixel stream
// and emits one reduced pixel per grid point as an addressed write, with a done/ack handshake.
module crop_downsample_grid #(
    parameter int unsigned IN_W    = 12,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned FRAME_W = 640,
    parameter int unsigned X0      = 27,
    parameter int unsigned Y0      = 17,
    parameter int unsigned SX      = 21,
    parameter int unsigned SY      = 16,
    parameter int unsigned N_COLS  = 28,
    parameter int unsigned N_ROWS  = 28,
    parameter int unsigned MODE    = 0,
    parameter int unsigned ACC_LEN = 4,
    parameter int unsigned ADDR_W  = $clog2(N_COLS * N_ROWS)
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              buf_rst,
    input  logic              iSTART,
    input  logic              iDVAL,
    input  logic [9:0]        iY,
    input  logic [IN_W-1:0]   iDATA,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [OUT_W-1:0]  oWR_DATA,
    output logic              oBUSY,
    output logic              oDONE,
    input  logic              iACK
);

    localparam int unsigned XW    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    // Point sampling is the one-pixel average, so both modes share one datapath.
    localparam int unsigned LEN   = (MODE == 1) ? ACC_LEN : 1;
    localparam int unsigned SH    = $clog2(LEN);
    localparam int unsigned ACC_W = IN_W + SH;
    localparam int unsigned CNT_W = (SH > 0) ? SH : 1;
    localparam int unsigned CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int unsigned RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned DSH   = SH + IN_W - OUT_W;

    if (X0 + (N_COLS - 1) * SX + ACC_LEN > FRAME_W) begin : g_bad_window
        $error("crop_downsample_grid: sample window exceeds FRAME_W");
    end
    if (ACC_LEN == 0 || (ACC_LEN & (ACC_LEN - 1)) != 0 || ACC_LEN > SX) begin : g_bad_acc
        $error("crop_downsample_grid: ACC_LEN must be a power of 2 in 1..SX");
    end
    if (OUT_W > IN_W || SX == 0 || SY == 0) begin : g_bad_width
        $error("crop_downsample_grid: illegal OUT_W or stride");
    end

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q;
    logic [XW-1:0]     col_x_q, col_x_d;
    logic [9:0]        row_y_q, row_y_d;
    logic [CW-1:0]     c_q, c_d;
    logic [RW-1:0]     r_q, r_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_on_q, acc_on_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [OUT_W-1:0]  wr_data_q, wr_data_d;
    logic              done_q, done_d;

    logic              pix;
    logic              hit;
    logic              last;
    logic [ACC_W-1:0]  sum;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_q <= '0;
        end else if (buf_rst) begin
            x_q <= '0;
        end else if (iDVAL) begin
            x_q <= (x_q == XW'(FRAME_W - 1)) ? '0 : x_q + XW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        col_x_d   = col_x_q;
        row_y_d   = row_y_q;
        c_d       = c_q;
        r_d       = r_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        acc_on_d  = acc_on_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = (state_q == StDone) && !iACK;

        pix  = iDVAL && ((state_q == StCapture) ||
                         (state_q == StArmed && x_q == '0 && iY == '0));
        hit  = !acc_on_q && (iY == row_y_q) && (x_q == col_x_q);
        sum  = (acc_on_q ? acc_q : '0) + ACC_W'(iDATA);
        last = acc_on_q ? (cnt_q == CNT_W'(LEN - 1)) : (LEN == 1);

        unique case (state_q)
            StIdle: begin
                col_x_d  = XW'(X0);
                row_y_d  = 10'(Y0);
                c_d      = '0;
                r_d      = '0;
                acc_on_d = 1'b0;
                cnt_d    = '0;
                addr_d   = '0;
                if (iSTART) state_d = StArmed;
            end
            StArmed:   if (pix) state_d = StCapture;
            StCapture: ;
            StDone:    if (iACK) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (pix && (acc_on_q || hit)) begin
            if (last) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                // Top OUT_W bits of the IN_W-bit average, taken straight from the sum.
                wr_data_d = OUT_W'(sum >> DSH);
                addr_d    = addr_q + ADDR_W'(1);
                acc_on_d  = 1'b0;
                if (c_q == CW'(N_COLS - 1)) begin
                    c_d     = '0;
                    col_x_d = XW'(X0);
                    row_y_d = row_y_q + 10'(SY);
                    r_d     = r_q + RW'(1);
                    if (r_q == RW'(N_ROWS - 1)) state_d = StDone;
                end else begin
                    c_d     = c_q + CW'(1);
                    col_x_d = col_x_q + XW'(SX);
                end
            end else begin
                acc_d    = sum;
                acc_on_d = 1'b1;
                cnt_d    = acc_on_q ? cnt_q + CNT_W'(1) : CNT_W'(1);
            end
        end

        if (buf_rst) begin
            state_d   = StIdle;
            col_x_d   = '0;
            row_y_d   = '0;
            c_d       = '0;
            r_d       = '0;
            acc_d     = '0;
            cnt_d     = '0;
            acc_on_d  = 1'b0;
            addr_d    = '0;
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= StIdle;
            col_x_q   <= '0;
            row_y_q   <= '0;
            c_q       <= '0;
            r_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            acc_on_q  <= 1'b0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_x_q   <= col_x_d;
            row_y_q   <= row_y_d;
            c_q       <= c_d;
            r_q       <= r_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            acc_on_q  <= acc_on_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign oWR_EN   = wr_en_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oBUSY    = (state_q == StArmed) || (state_q == StCapture);
    assign oDONE    = done_q;

endmodule

// File: tb/tb_crop_downsample_grid.sv
// Directed bench for crop_downsample_grid on a small 16x7 frame with a 3x3 grid,
// run side by side in point-sample, 4-pixel average and 1-pixel average configurations.
module tb_crop_downsample_grid;

    localparam int FW    = 16;
    localparam int LINES = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_bufrst, s_start, s_dval, s_ack;
    logic [9:0] s_y;
    logic [11:0] s_data;

    logic       wr_en   [3];
    logic [3:0] wr_addr [3];
    logic [7:0] wr_data [3];
    logic       busy    [3];
    logic       done    [3];

    int cyc = 0;
    int n_asrt = 0;
    int n_fail = 0;

    // Grid points (2,7,12) x (1,3,5); iDATA = X*256 + Y*16.
    int exp_m0 [9] = '{33, 113, 193, 35, 115, 195, 37, 117, 197};
    int exp_m1 [9] = '{57, 137, 217, 59, 139, 219, 61, 141, 221};
    int p0 [9];
    int p1 [9];

    int w_addr [3][128];
    int w_data [3][128];
    int w_cyc  [3][128];
    int w_busy [3][128];
    int n_wr [3] = '{0, 0, 0};
    int base [3];
    int done_cyc [3] = '{0, 0, 0};
    logic done_prev [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crop_downsample_grid #(
        .IN_W(12), .OUT_W(8), .FRAME_W(FW), .X0(2), .Y0(1), .SX(5), .SY(2),
        .N_COLS(3), .N_ROWS(3), .MODE(0), .ACC_LEN(4)
    ) u0 (
        .iCLK(clk), .iRST(rst_n), .buf_rst(s_bufrst), .iSTART(s_start), .iDVAL(s_dval),
        .iY(s_y), .iDATA(s_data), .oWR_EN(wr_en[0]), .oWR_ADDR(wr_addr[0]),
        .oWR_DATA(wr_data[0]), .oBUSY(busy[0]), .oDONE(done[0]), .iACK(s_ack)
    );

    crop_downsample_grid #(
        .IN_W(12), .OUT_W(8), .FRAME_W(FW), .X0(2), .Y0(1), .SX(5), .SY(2),
        .N_COLS(3), .N_ROWS(3), .MODE(1), .ACC_LEN(4)
    ) u1 (
        .iCLK(clk), .iRST(rst_n), .buf_rst(s_bufrst), .iSTART(s_start), .iDVAL(s_dval),
        .iY(s_y), .iDATA(s_data), .oWR_EN(wr_en[1]), .oWR_ADDR(wr_addr[1]),
        .oWR_DATA(wr_data[1]), .oBUSY(busy[1]), .oDONE(done[1]), .iACK(s_ack)
    );

    crop_downsample_grid #(
        .IN_W(12), .OUT_W(8), .FRAME_W(FW), .X0(2), .Y0(1), .SX(5), .SY(2),
        .N_COLS(3), .N_ROWS(3), .MODE(1), .ACC_LEN(1)
    ) u2 (
        .iCLK(clk), .iRST(rst_n), .buf_rst(s_bufrst), .iSTART(s_start), .iDVAL(s_dval),
        .iY(s_y), .iDATA(s_data), .oWR_EN(wr_en[2]), .oWR_ADDR(wr_addr[2]),
        .oWR_DATA(wr_data[2]), .oBUSY(busy[2]), .oDONE(done[2]), .iACK(s_ack)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_en[i] === 1'b1 && n_wr[i] < 128) begin
                w_addr[i][n_wr[i]] <= int'(wr_addr[i]);
                w_data[i][n_wr[i]] <= int'(wr_data[i]);
                w_cyc[i][n_wr[i]]  <= cyc;
                w_busy[i][n_wr[i]] <= int'(busy[i]);
                n_wr[i]            <= n_wr[i] + 1;
            end
            if (done[i] === 1'b1 && done_prev[i] !== 1'b1) done_cyc[i] <= cyc;
            done_prev[i] <= done[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asrt++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) base[i] = n_wr[i];
    endtask

    task automatic pulse_start();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    // Full lines y_first..y_last; optional random idle cycles and an iSTART on pixel start_at.
    task automatic send_lines(input int y_first, input int y_last, input int gap_pct,
                              input int start_at);
        int idx = 0;
        for (int y = y_first; y <= y_last; y++) begin
            for (int x = 0; x < FW; x++) begin
                while (int'($urandom_range(99)) < gap_pct) begin
                    tick();
                    s_dval  = 1'b0;
                    s_start = 1'b0;
                end
                tick();
                s_dval  = 1'b1;
                s_y     = 10'(y);
                s_data  = 12'(x * 256 + y * 16);
                s_start = (idx == start_at);
                if (y >= 1 && y <= 5 && (y % 2) == 1) begin
                    for (int c = 0; c < 3; c++) begin
                        if (x == 2 + 5 * c) p0[((y - 1) / 2) * 3 + c] = cyc;
                        if (x == 5 + 5 * c) p1[((y - 1) / 2) * 3 + c] = cyc;
                    end
                end
                idx++;
            end
        end
        tick();
        s_dval  = 1'b0;
        s_start = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int j;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_u%0d_count", tag, i), n_wr[i] - base[i], 9);
            for (int k = 0; k < 9; k++) begin
                j = base[i] + k;
                chk($sformatf("%s_u%0d_addr%0d", tag, i, k), w_addr[i][j], k);
                chk($sformatf("%s_u%0d_data%0d", tag, i, k), w_data[i][j],
                    (i == 1) ? exp_m1[k] : exp_m0[k]);
                chk($sformatf("%s_u%0d_lat%0d", tag, i, k), w_cyc[i][j],
                    ((i == 1) ? p1[k] : p0[k]) + 1);
            end
            j = base[i] + 8;
            chk($sformatf("%s_u%0d_busy_last", tag, i), w_busy[i][j], 0);
            chk($sformatf("%s_u%0d_done_time", tag, i), done_cyc[i], w_cyc[i][j] + 1);
            chk($sformatf("%s_u%0d_done", tag, i), done[i], 1);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        s_bufrst = 1'b0;
        s_start  = 1'b0;
        s_dval   = 1'b0;
        s_ack    = 1'b0;
        s_y      = '0;
        s_data   = '0;
        repeat (3) tick();

        // Reset values
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_u%0d_wr_en", i), wr_en[i], 0);
            chk($sformatf("rst_u%0d_addr", i), wr_addr[i], 0);
            chk($sformatf("rst_u%0d_data", i), wr_data[i], 0);
            chk($sformatf("rst_u%0d_busy", i), busy[i], 0);
            chk($sformatf("rst_u%0d_done", i), done[i], 0);
        end
        rst_n = 1'b1;
        tick();

        // Clean frame
        snap();
        pulse_start();
        chk("start_busy", busy[0], 1);
        send_lines(0, LINES - 1, 0, -1);
        repeat (3) tick();
        check_writes("clean");

        // DONE holds without iACK
        repeat (50) tick();
        chk("hold_done_u0", done[0], 1);
        chk("hold_done_u1", done[1], 1);
        chk("hold_busy_u0", busy[0], 0);

        // iACK together with iSTART returns to IDLE, not ARMED
        s_ack   = 1'b1;
        s_start = 1'b1;
        tick();
        s_ack   = 1'b0;
        s_start = 1'b0;
        chk("ack_done_low", done[0], 0);
        chk("ack_busy_low", busy[0], 0);
        tick();
        chk("ack_not_armed", busy[1], 0);
        snap();
        send_lines(0, LINES - 1, 0, -1);
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("idle_no_writes_u%0d", i), n_wr[i] - base[i], 0);

        // Frame with random iDVAL gaps
        snap();
        pulse_start();
        send_lines(0, LINES - 1, 30, -1);
        repeat (3) tick();
        check_writes("gaps");
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;

        // Arm mid-frame, then iSTART during the captured frame is ignored
        snap();
        send_lines(0, LINES - 1, 0, 40);
        for (int i = 0; i < 3; i++)
            chk($sformatf("arm_mid_no_writes_u%0d", i), n_wr[i] - base[i], 0);
        chk("arm_mid_busy", busy[0], 1);
        send_lines(0, LINES - 1, 0, 50);
        repeat (3) tick();
        check_writes("arm");
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;

        // buf_rst mid-capture after the first two grid rows
        snap();
        pulse_start();
        send_lines(0, 3, 0, -1);
        s_bufrst = 1'b1;
        tick();
        s_bufrst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bufrst_u%0d_count", i), n_wr[i] - base[i], 6);
            chk($sformatf("bufrst_u%0d_wr_en", i), wr_en[i], 0);
            chk($sformatf("bufrst_u%0d_addr", i), wr_addr[i], 0);
            chk($sformatf("bufrst_u%0d_data", i), wr_data[i], 0);
            chk($sformatf("bufrst_u%0d_busy", i), busy[i], 0);
        end
        send_lines(4, LINES - 1, 0, -1);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bufrst_after_u%0d_count", i), n_wr[i] - base[i], 6);
            chk($sformatf("bufrst_after_u%0d_done", i), done[i], 0);
        end
        snap();
        pulse_start();
        send_lines(0, LINES - 1, 0, -1);
        repeat (3) tick();
        check_writes("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
